// File: rtl/ram_access_ctrl_if.sv
// Client request/response interface of ram_access_ctrl.
// Handshake contract: a request transfers on a rising edge where req_valid
// and req_ready are both 1. The client holds req_we/req_addr/req_wdata
// stable while req_valid is high and not yet accepted. rsp_valid is a
// one-cycle pulse with no back-pressure; rsp_rdata holds until the next
// response.
interface ram_access_ctrl_if #(
    parameter int AW = 10,
    parameter int DW = 32
);
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;

    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/ram_access_ctrl.sv
// ram_access_ctrl: sequencer in front of a single-port RAM.
// Runs an init sweep (data = 2*k mod 256 for k = 0..INIT_WORDS-1) and
// serves single read/write requests from the client interface.
// Optional feature macro RAM_ACCESS_CTRL_BOUNDS_EN: adds addr_err and drops
// accepted requests whose address is >= DEPTH.
// state_dbg exposes the FSM state: 0 IDLE, 1 INIT, 2 WRITE, 3 RD_WAIT.
module ram_access_ctrl #(
    parameter int AW         = 10,
    parameter int DW         = 32,
    parameter int DEPTH      = 1024,
    parameter int INIT_WORDS = 32,
    parameter int RD_LAT     = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                init_start,
    output logic                init_done,
    output logic                busy,
    ram_access_ctrl_if.slave    cli,
    output logic [AW-1:0]       ram_addr,
    output logic [DW-1:0]       ram_wdata,
    output logic                ram_write,
    output logic                ram_select,
    input  logic [DW-1:0]       ram_rdata,
`ifdef RAM_ACCESS_CTRL_BOUNDS_EN
    output logic                addr_err,
`endif
    output logic [1:0]          state_dbg
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        INIT    = 2'd1,
        WRITE   = 2'd2,
        RD_WAIT = 2'd3
    } state_t;

    state_t        state, state_d;
    logic [AW:0]   init_cnt;     // one extra bit so INIT_WORDS == 2**AW fits
    logic [2:0]    lat_cnt;      // cycles spent in RD_WAIT, 0..RD_LAT
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic          rsp_valid_q;
    logic [DW-1:0] rsp_rdata_q;
    logic          accept;
    logic          drop;
    logic          init_last;    // INIT cycle after the final write
    logic          rd_last;      // RD_WAIT cycle in which ram_rdata is valid

    assign init_last = (init_cnt == (AW+1)'(INIT_WORDS));
    assign rd_last   = (lat_cnt == 3'(RD_LAT));

`ifdef RAM_ACCESS_CTRL_BOUNDS_EN
    logic addr_err_q;
    assign addr_err = addr_err_q;
    // Out-of-range requests are consumed but never reach the RAM.
    assign drop = accept && (32'(cli.req_addr) >= 32'(DEPTH));
`else
    assign drop = 1'b0;
`endif

    assign state_dbg     = state;
    assign busy          = (state != IDLE);
    assign cli.rsp_valid = rsp_valid_q;
    assign cli.rsp_rdata = rsp_rdata_q;

    // Next-state and RAM strobe decode; strobes default to idle.
    always_comb begin
        state_d       = state;
        ram_addr      = addr_q;
        ram_wdata     = wdata_q;
        ram_write     = 1'b0;
        ram_select    = 1'b0;
        init_done     = 1'b0;
        cli.req_ready = 1'b0;
        accept        = 1'b0;
        case (state)
            IDLE: begin
                cli.req_ready = 1'b1;
                // init_start wins over a simultaneous request.
                if (init_start) begin
                    state_d = INIT;
                end else if (cli.req_valid) begin
                    accept = 1'b1;
                    if (!drop) begin
                        state_d = cli.req_we ? WRITE : RD_WAIT;
                    end
                end
            end
            INIT: begin
                if (init_last) begin
                    init_done = 1'b1;
                    state_d   = IDLE;
                end else begin
                    ram_addr   = init_cnt[AW-1:0];
                    ram_wdata  = DW'((32'(init_cnt) << 1) & 32'hFF);
                    ram_write  = 1'b1;
                    ram_select = 1'b1;
                end
            end
            WRITE: begin
                ram_write  = 1'b1;
                ram_select = 1'b1;
                state_d    = IDLE;
            end
            RD_WAIT: begin
                // Read strobe only in the first RD_WAIT cycle.
                if (lat_cnt == 3'd0) begin
                    ram_select = 1'b1;
                end
                if (rd_last) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register, counters, request capture and response register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            init_cnt    <= '0;
            lat_cnt     <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
`ifdef RAM_ACCESS_CTRL_BOUNDS_EN
            addr_err_q  <= 1'b0;
`endif
        end else begin
            state       <= state_d;
            rsp_valid_q <= 1'b0;
`ifdef RAM_ACCESS_CTRL_BOUNDS_EN
            addr_err_q  <= drop;
`endif
            case (state)
                IDLE: begin
                    init_cnt <= '0;
                    lat_cnt  <= '0;
                    if (accept && !drop) begin
                        addr_q  <= cli.req_addr;
                        wdata_q <= cli.req_wdata;
                    end
                end
                INIT: begin
                    if (!init_last) begin
                        init_cnt <= init_cnt + (AW+1)'(1);
                    end
                end
                RD_WAIT: begin
                    lat_cnt <= lat_cnt + 3'd1;
                    if (rd_last) begin
                        rsp_valid_q <= 1'b1;
                        rsp_rdata_q <= ram_rdata;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_access_ctrl.sv
// Self-checking bench for ram_access_ctrl: RAM model, reference memory,
// response scoreboard and directed plus randomized request traffic.
module tb_ram_access_ctrl;

    localparam int AW         = 10;
    localparam int DW         = 32;
`ifdef RAM_ACCESS_CTRL_BOUNDS_EN
    localparam int DEPTH      = 512;
`else
    localparam int DEPTH      = 1024;
`endif
    localparam int INIT_WORDS = 32;
    localparam int RD_LAT     = 1;
    localparam int TOP_ADDR   = DEPTH - 1;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          init_start = 1'b0;
    logic          init_done;
    logic          busy;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic          ram_write;
    logic          ram_select;
    logic [DW-1:0] ram_rdata;
    logic [1:0]    state_dbg;
`ifdef RAM_ACCESS_CTRL_BOUNDS_EN
    logic          addr_err;
`endif

    ram_access_ctrl_if #(.AW(AW), .DW(DW)) cli ();

    ram_access_ctrl #(
        .AW(AW), .DW(DW), .DEPTH(DEPTH), .INIT_WORDS(INIT_WORDS), .RD_LAT(RD_LAT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .init_start (init_start),
        .init_done  (init_done),
        .busy       (busy),
        .cli        (cli.slave),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),
        .ram_write  (ram_write),
        .ram_select (ram_select),
        .ram_rdata  (ram_rdata),
`ifdef RAM_ACCESS_CTRL_BOUNDS_EN
        .addr_err   (addr_err),
`endif
        .state_dbg  (state_dbg)
    );

    // ---------------- RAM model (1-cycle read latency) ----------------
    logic [DW-1:0] ram_mem [1024];
    always @(posedge clk) begin
        if (ram_select && ram_write) ram_mem[ram_addr] <= ram_wdata;
        if (ram_select && !ram_write) ram_rdata <= ram_mem[ram_addr];
    end

    // ---------------- reference model / scoreboard ----------------
    logic [DW-1:0] ref_mem [int];
    int            known_q[$];
    logic [DW-1:0] exp_q[$];
    int            n_checks = 0;
    int            n_pass = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic ref_write(input int a, input logic [DW-1:0] d);
        if (!ref_mem.exists(a)) known_q.push_back(a);
        ref_mem[a] = d;
    endtask

    // Response scoreboard and strobe invariant, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst_n && cli.rsp_valid) begin
            if (exp_q.size() == 0) check("rsp_unexpected", 1, 0);
            else check("rsp_rdata", cli.rsp_rdata, exp_q.pop_front());
        end
        if (ram_write) check("write_needs_select", ram_select, 1);
    end

    // ---------------- driver tasks ----------------
    task automatic do_reset(input int cycles);
        rst_n = 1'b0;
        repeat (cycles) @(negedge clk);
        check("rst_req_ready", cli.req_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_select", ram_select, 0);
        check("rst_write", ram_write, 0);
        check("rst_rsp_valid", cli.rsp_valid, 0);
        check("rst_init_done", init_done, 0);
        check("rst_state_dbg", state_dbg, 0);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (!cli.req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!cli.req_ready) check(tag, 0, 1);
    endtask

    task automatic run_init();
        init_start = 1'b1;
        @(negedge clk);
        init_start = 1'b0;
        for (int k = 0; k < INIT_WORDS; k++) begin
            check("init_write", ram_write, 1);
            check("init_addr", ram_addr, k);
            check("init_data", ram_wdata, (2 * k) % 256);
            check("init_busy", busy, 1);
            check("init_done_early", init_done, 0);
            ref_write(k, DW'((2 * k) % 256));
            @(negedge clk);
        end
        check("init_done_pulse", init_done, 1);
        check("init_done_busy", busy, 1);
        check("init_done_select", ram_select, 0);
        @(negedge clk);
        check("init_done_width", init_done, 0);
        check("init_idle", busy, 0);
    endtask

    task automatic do_write(input int a, input logic [DW-1:0] d);
        cli.req_valid = 1'b1;
        cli.req_we    = 1'b1;
        cli.req_addr  = AW'(a);
        cli.req_wdata = d;
        wait_ready("wr_ready_timeout");
        @(negedge clk);
        cli.req_valid = 1'b0;
        check("wr_ready_low", cli.req_ready, 0);
        check("wr_strobe", ram_write, 1);
        check("wr_addr", ram_addr, a);
        check("wr_data", ram_wdata, d);
        ref_write(a, d);
        @(negedge clk);
        check("wr_ready_back", cli.req_ready, 1);
        check("wr_no_rsp", cli.rsp_valid, 0);
    endtask

    // Called on the cycle in which a read is about to be accepted.
    task automatic read_tail(input int a);
        int n;
        exp_q.push_back(ref_mem[a]);
        @(negedge clk);
        cli.req_valid = 1'b0;
        check("rd_select", ram_select, 1);
        check("rd_no_write", ram_write, 0);
        check("rd_addr", ram_addr, a);
        n = 1;
        while (!cli.rsp_valid && n < 20) begin
            @(negedge clk);
            check("rd_no_write_wait", ram_write, 0);
            n++;
        end
        check("rd_latency", n, RD_LAT + 2);
        @(negedge clk);
        check("rsp_pulse_width", cli.rsp_valid, 0);
    endtask

    task automatic do_read(input int a);
        cli.req_valid = 1'b1;
        cli.req_we    = 1'b0;
        cli.req_addr  = AW'(a);
        wait_ready("rd_ready_timeout");
        read_tail(a);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n;
        int a;
        logic [DW-1:0] d;
        logic [DW-1:0] hold;

        cli.req_valid = 1'b0;
        cli.req_we    = 1'b0;
        cli.req_addr  = '0;
        cli.req_wdata = '0;

        // Reset, then init sweep.
        do_reset(3);
        run_init();

        // Read back an init word: 2*5 = 10.
        check("model_addr5", ref_mem[5], 10);
        do_read(5);

        // Write then read the top address.
        do_write(TOP_ADDR, 32'hDEADBEEF);
        do_read(TOP_ADDR);

        // init_start and a read in the same idle cycle: init first.
        cli.req_valid = 1'b1;
        cli.req_we    = 1'b0;
        cli.req_addr  = AW'(7);
        init_start    = 1'b1;
        @(negedge clk);
        init_start = 1'b0;
        n = 0;
        while (!cli.req_ready && n < 200) begin
            if (ram_write) check("sim_init_addr", ram_addr, n);
            @(negedge clk);
            n++;
        end
        check("sim_wait_cycles", n, INIT_WORDS + 1);
        read_tail(7);

        // Reset during init write k = 10.
        init_start = 1'b1;
        @(negedge clk);
        init_start = 1'b0;
        repeat (10) @(negedge clk);
        check("mid_init_addr", ram_addr, 10);
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_select", ram_select, 0);
        check("abort_busy", busy, 0);
        rst_n = 1'b1;
        n = 0;
        repeat (40) begin
            if (init_done) n++;
            @(negedge clk);
        end
        check("abort_no_done", n, 0);
        run_init();

`ifdef RAM_ACCESS_CTRL_BOUNDS_EN
        // Out-of-range read is dropped, then a normal read completes.
        cli.req_valid = 1'b1;
        cli.req_we    = 1'b0;
        cli.req_addr  = AW'(600);
        wait_ready("oor_ready_timeout");
        @(negedge clk);
        cli.req_valid = 1'b0;
        check("oor_addr_err", addr_err, 1);
        check("oor_no_select", ram_select, 0);
        check("oor_idle", busy, 0);
        n = 0;
        repeat (5) begin
            @(negedge clk);
            if (addr_err || ram_select || cli.rsp_valid) n++;
        end
        check("oor_quiet", n, 0);
        do_write(100, 32'h0BAD_F00D);
        do_read(100);
`endif

        // Randomized traffic.
        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 1) == 1) begin
                a = $urandom_range(0, DEPTH - 1);
                d = $urandom;
                do_write(a, d);
            end else begin
                a = known_q[$urandom_range(0, known_q.size() - 1)];
                do_read(a);
            end
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        // rsp_rdata holds the last response.
        hold = cli.rsp_rdata;
        repeat (3) @(negedge clk);
        check("rsp_hold", cli.rsp_rdata, hold);
        check("exp_q_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Global time bound.
    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
